// File: rtl/exec_muldiv_unit.sv
// ----------------------------------------------------------------------------
// exec_muldiv_unit
// Iterative multiply/divide unit for the execute stage. Accepts MULT, MULTU,
// DIV and DIVU from the decode->execute register. It produces HI/LO after
// a fixed latency and holds the upstream pipeline (stall_out) while it works.
// Each result carries the active-list tag of the issuing instruction.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   flush, global_flush       abort the operation in flight
//   start_in, op_in           issue strobe, 00 MULT 01 MULTU 10 DIV 11 DIVU
//   rs_in, rt_in              multiplicand/dividend, multiplier/divisor
//   active_list_index_in      tag of the issuing instruction
//   stall_out                 hold the upstream pipeline registers
//   done_out                  one-cycle pulse, result outputs valid
//   hi_out, lo_out            MUL: product high/low, DIV: remainder/quotient
//   div_by_zero_out           divide with rt==0 (valid with done_out)
//   active_list_index_out     tag latched at accept (valid with done_out)
// ----------------------------------------------------------------------------
module exec_muldiv_unit #(
    parameter int DATA_WIDTH      = 32,
    parameter int FREE_LIST_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       global_flush,
    input  logic                       start_in,
    input  logic [1:0]                 op_in,
    input  logic [DATA_WIDTH-1:0]      rs_in,
    input  logic [DATA_WIDTH-1:0]      rt_in,
    input  logic [FREE_LIST_WIDTH-1:0] active_list_index_in,
    output logic                       stall_out,
    output logic                       done_out,
    output logic [DATA_WIDTH-1:0]      hi_out,
    output logic [DATA_WIDTH-1:0]      lo_out,
    output logic                       div_by_zero_out,
    output logic [FREE_LIST_WIDTH-1:0] active_list_index_out
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]           count;
    logic                       op_div;
    logic                       neg_res;   // negate product / quotient in FIX
    logic                       neg_rem;   // remainder takes the sign of rs
    logic                       dbz;
    logic [FREE_LIST_WIDTH-1:0] tag;
    logic [W-1:0]               mcand;     // |multiplicand| or |divisor|
    logic [W-1:0]               acc_hi;    // product high half / partial remainder
    logic [W-1:0]               acc_lo;    // multiplier bits / dividend->quotient

    logic kill;
    logic accept;
    logic last;
    logic op_signed;

    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;
    logic [W:0]     div_diff;
    logic           div_ok;
    logic [2*W-1:0] prod_fixed;
    logic [W-1:0]   quo_fixed;
    logic [W-1:0]   rem_fixed;

    function automatic logic [W-1:0] mag(input logic signed [W-1:0] v);
        return v[W-1] ? -v : v;
    endfunction

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    assign kill      = flush | global_flush;
    assign accept    = (state == S_IDLE) & start_in & ~kill;
    assign last      = (count == CNT_W'(W - 1));
    assign op_signed = ~op_in[0];

    assign stall_out = (state == S_MUL) | (state == S_DIV) | (state == S_FIX) | accept;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = op_in[1] ? S_DIV : S_MUL;
            S_MUL,
            S_DIV:   if (last) state_next = S_FIX;
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        // A flush abandons the operation from any busy state.
        if (state != S_IDLE && kill) state_next = S_IDLE;
    end

    // Shift-add step: add the multiplicand when the current multiplier bit is
    // set, then shift the 2W accumulator right, consuming that bit.
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);

    // Restoring step: bring down the next dividend bit, trial-subtract.
    // The remainder stays below the divisor, so bit W of the difference
    // is a reliable borrow.
    assign div_shift = {acc_hi, acc_lo[W-1]};
    assign div_diff  = div_shift - {1'b0, mcand};
    assign div_ok    = ~div_diff[W];

    // Sign correction. With a zero divisor the quotient is forced to all
    // ones; the remainder already holds |rs|, so the rs-sign rule restores rs.
    assign prod_fixed = neg_2w({acc_hi, acc_lo}, neg_res);
    assign quo_fixed  = dbz ? '1 : neg_w(acc_lo, neg_res);
    assign rem_fixed  = neg_w(acc_hi, neg_rem);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                 <= S_IDLE;
            count                 <= '0;
            op_div                <= 1'b0;
            neg_res               <= 1'b0;
            neg_rem               <= 1'b0;
            dbz                   <= 1'b0;
            tag                   <= '0;
            mcand                 <= '0;
            acc_hi                <= '0;
            acc_lo                <= '0;
            done_out              <= 1'b0;
            hi_out                <= '0;
            lo_out                <= '0;
            div_by_zero_out       <= 1'b0;
            active_list_index_out <= '0;
        end else begin
            state    <= state_next;
            done_out <= 1'b0;
            case (state)
                // IDLE -> MUL/DIV: latch operand magnitudes, signs and tag
                S_IDLE: begin
                    if (accept) begin
                        count   <= '0;
                        op_div  <= op_in[1];
                        neg_res <= op_signed & (rs_in[W-1] ^ rt_in[W-1]);
                        neg_rem <= op_signed & rs_in[W-1];
                        dbz     <= op_in[1] & (rt_in == '0);
                        tag     <= active_list_index_in;
                        acc_hi  <= '0;
                        if (op_in[1]) begin
                            mcand  <= op_signed ? mag(rt_in) : rt_in;
                            acc_lo <= op_signed ? mag(rs_in) : rs_in;
                        end else begin
                            mcand  <= op_signed ? mag(rs_in) : rs_in;
                            acc_lo <= op_signed ? mag(rt_in) : rt_in;
                        end
                    end
                end
                // MUL iterations: one multiplier bit per cycle
                S_MUL: begin
                    count  <= count + 1'b1;
                    acc_hi <= mul_sum[W:1];
                    acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
                end
                // DIV iterations: one quotient bit per cycle
                S_DIV: begin
                    count  <= count + 1'b1;
                    acc_hi <= div_ok ? div_diff[W-1:0] : div_shift[W-1:0];
                    acc_lo <= {acc_lo[W-2:0], div_ok};
                end
                // FIX -> DONE: register the sign-corrected result
                S_FIX: begin
                    if (!kill) begin
                        if (op_div) begin
                            hi_out          <= rem_fixed;
                            lo_out          <= quo_fixed;
                            div_by_zero_out <= dbz;
                        end else begin
                            {hi_out, lo_out} <= prod_fixed;
                            div_by_zero_out  <= 1'b0;
                        end
                        active_list_index_out <= tag;
                        done_out              <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_muldiv_unit.sv
module tb_exec_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        global_flush;
    logic        start_in;
    logic [1:0]  op_in;
    logic [31:0] rs_in;
    logic [31:0] rt_in;
    logic [2:0]  tag_in;
    logic        stall_out;
    logic        done_out;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_by_zero_out;
    logic [2:0]  tag_out;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    exec_muldiv_unit #(.DATA_WIDTH(32), .FREE_LIST_WIDTH(3)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .flush                 (flush),
        .global_flush          (global_flush),
        .start_in              (start_in),
        .op_in                 (op_in),
        .rs_in                 (rs_in),
        .rt_in                 (rt_in),
        .active_list_index_in  (tag_in),
        .stall_out             (stall_out),
        .done_out              (done_out),
        .hi_out                (hi_out),
        .lo_out                (lo_out),
        .div_by_zero_out       (div_by_zero_out),
        .active_list_index_out (tag_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Drive an op at a negedge, confirm the accept stall, return on the accept edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] t);
        @(negedge clk);
        start_in = 1'b1;
        op_in    = op;
        rs_in    = a;
        rt_in    = b;
        tag_in   = t;
        #1;
        chk("accept_stall", stall_out, 1);
        @(posedge clk);
    endtask

    // Called right after the accept edge. lat = negedges until done_out is seen,
    // i.e. the number of edges from accept to the edge that samples done_out.
    task automatic wait_done(input bit hold, output int lat, output int stalls);
        lat    = 0;
        stalls = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) start_in = 1'b0;
            if (done_out) begin
                lat = k;
                break;
            end
            if (stall_out) stalls++;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] t,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dbz);
        int lat, stalls;
        issue(op, a, b, t);
        wait_done(1'b0, lat, stalls);
        chk({name, "_lat"},   lat, 34);
        chk({name, "_stall"}, stalls, 33);
        chk({name, "_hi"},    hi_out, exp_hi);
        chk({name, "_lo"},    lo_out, exp_lo);
        chk({name, "_dbz"},   div_by_zero_out, exp_dbz);
        chk({name, "_tag"},   tag_out, t);
        @(negedge clk);
        chk({name, "_pulse"}, done_out, 0);
    endtask

    initial begin
        int lat, stalls;
        rst          = 1'b1;
        flush        = 1'b0;
        global_flush = 1'b0;
        start_in     = 1'b0;
        op_in        = 2'b00;
        rs_in        = '0;
        rt_in        = '0;
        tag_in       = '0;
        repeat (2) @(negedge clk);
        chk("rst_stall", stall_out, 0);
        chk("rst_done",  done_out, 0);
        chk("rst_hilo",  {hi_out, lo_out}, 64'h0);
        chk("rst_dbz",   div_by_zero_out, 0);
        chk("rst_tag",   tag_out, 0);
        rst = 1'b0;

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd7,         3'd5,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         3'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_negrt", OP_DIV,   32'd7,         32'hFFFF_FFFE, 3'd3,
               32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run_op("divu",      OP_DIVU,  32'd7,         32'd2,         3'd6,
               32'd1,         32'd3,         1'b0);
        run_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 3'd7,
               32'd0,         32'h8000_0000, 1'b0);
        run_op("divu_zero", OP_DIVU,  32'd100,       32'd0,         3'd4,
               32'd100,       32'hFFFF_FFFF, 1'b1);
        run_op("div_zero",  OP_DIV,   32'hFFFF_FFF9, 32'd0,         3'd4,
               32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);

        // global_flush 10 cycles into a multiply
        issue(OP_MULTU, 32'd2, 32'd3, 3'd2);
        begin
            bit early_done;
            early_done = 1'b0;
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                if (k == 1) start_in = 1'b0;
                if (done_out) early_done = 1'b1;
            end
            chk("gf_no_early_done", early_done, 0);
        end
        global_flush = 1'b1;
        @(negedge clk);
        global_flush = 1'b0;
        #1;
        chk("gf_stall", stall_out, 0);
        chk("gf_done",  done_out, 0);
        chk("gf_hilo",  {hi_out, lo_out}, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
        chk("gf_tag",   tag_out, 4);
        run_op("after_gf", OP_DIVU, 32'd7, 32'd2, 3'd1, 32'd1, 32'd3, 1'b0);

        // start held through DONE: one done pulse, next op taken right after
        issue(OP_MULTU, 32'd2, 32'd3, 3'd6);
        wait_done(1'b1, lat, stalls);
        chk("b2b_lat",        lat, 34);
        chk("b2b_lo",         lo_out, 6);
        chk("b2b_done_stall", stall_out, 0);
        op_in  = OP_DIVU;
        rs_in  = 32'd100;
        rt_in  = 32'd7;
        tag_in = 3'd7;
        @(negedge clk);
        chk("b2b_single_done", done_out, 0);
        chk("b2b_reaccept",    stall_out, 1);
        @(posedge clk);
        wait_done(1'b0, lat, stalls);
        chk("b2b2_lat", lat, 34);
        chk("b2b2_hilo", {hi_out, lo_out}, {32'd2, 32'd14});
        chk("b2b2_tag", tag_out, 7);

        // reset pulse in the middle of a divide
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 3'd3);
        repeat (5) @(negedge clk);
        start_in = 1'b0;
        rst = 1'b1;
        #1;
        chk("mrst_stall", stall_out, 0);
        chk("mrst_done",  done_out, 0);
        chk("mrst_hilo",  {hi_out, lo_out}, 64'h0);
        chk("mrst_dbz",   div_by_zero_out, 0);
        chk("mrst_tag",   tag_out, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", OP_MULT, 32'hFFFF_FFFD, 32'd7, 3'd5,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
